riscv_ifu: RTL and testbench

RISCV_IFU -- requirements
Module: riscv_ifu

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/riscv_ifu_hwbuf.sv | 67 ++++++
 rtl/riscv_ifu.sv | 163 ++++++++++++++++
 tb/tb_riscv_ifu.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   ifu_state_t    : fetch request FSM states
//   IFU_BUF_DEPTH  : halfword buffer depth
//   IFU_CNT_W      : width of the halfword buffer occupancy count
//   is_compressed  : RVC length decode from the first halfword of an instruction
package riscv_pkg;

  localparam int unsigned IFU_BUF_DEPTH = 4;
  localparam int unsigned IFU_CNT_W     = $clog2(IFU_BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDrop
  } ifu_state_t;

  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/riscv_ifu_hwbuf.sv
// Halfword FIFO between the fetch port and the instruction issue stage.
// Slot 0 is always the oldest halfword; pops shift the contents down, pushes append at the
// current tail. Up to two halfwords can be pushed and popped in the same cycle.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   flush               : drop all contents (takes priority over push/pop)
//   push_cnt, push_hw0/1: number of halfwords to append (0..2), hw0 is appended first
//   pop_cnt             : number of halfwords to remove from the head (0..2)
//   count               : current occupancy (0..Depth)
//   hw0, hw1            : the two oldest halfwords
module riscv_ifu_hwbuf
  import riscv_pkg::*;
#(
  parameter int unsigned Depth = IFU_BUF_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [1:0]                   push_cnt,
  input  logic [15:0]                  push_hw0,
  input  logic [15:0]                  push_hw1,
  input  logic [1:0]                   pop_cnt,
  output logic [$clog2(Depth+1)-1:0]   count,
  output logic [15:0]                  hw0,
  output logic [15:0]                  hw1
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Depth*16-1:0] data_q, data_d;
  logic [Depth*16-1:0] shifted, push_vec;
  logic [CntW-1:0]     count_q, count_d;
  logic [CntW-1:0]     base;

  always_comb begin
    // Slots at or above count_q are kept at zero, so shifting and OR-ing in the pushed
    // halfwords at the new tail is enough to merge them.
    shifted  = data_q >> {pop_cnt, 4'b0000};
    base     = count_q - CntW'(pop_cnt);
    push_vec = '0;
    case (push_cnt)
      2'd1: push_vec[15:0] = push_hw0;
      2'd2: push_vec[31:0] = {push_hw1, push_hw0};
      default: ;
    endcase
    data_d  = shifted | (push_vec << {base, 4'b0000});
    count_d = count_q + CntW'(push_cnt) - CntW'(pop_cnt);
    if (flush) begin
      data_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign hw0   = data_q[15:0];
  assign hw1   = data_q[31:16];

endmodule

// File: rtl/riscv_ifu.sv
// Instruction fetch unit: fetches aligned 32-bit words, splits them into halfwords, and issues
// 16-bit (compressed) or 32-bit instructions one per cycle with a registered valid pulse.
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   redirect_vld, redirect_addr  : one-cycle PC change (bit 0 ignored)
//   stall                        : hold instruction issue
//   mem_req_vld/rdy/addr         : fetch request handshake, word-aligned address
//   mem_rsp_vld, mem_rsp_data    : fetch response (one request outstanding at most)
//   ifu_vld, ifu_addr, ifu_data  : issued instruction (addr/data hold while ifu_vld is low)
module riscv_ifu
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_vld,
  input  logic [31:0] redirect_addr,
  input  logic        stall,
  output logic        mem_req_vld,
  input  logic        mem_req_rdy,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_vld,
  input  logic [31:0] mem_rsp_data,
  output logic        ifu_vld,
  output logic [31:0] ifu_addr,
  output logic [31:0] ifu_data
);

  ifu_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_q, fetch_d;
  // Set when the next kept response starts mid-word, so its low halfword is not wanted.
  logic        skip_lo_q, skip_lo_d;
  logic        ifu_vld_q, ifu_vld_d;
  logic [31:0] ifu_addr_q, ifu_addr_d;
  logic [31:0] ifu_data_q, ifu_data_d;

  logic [IFU_CNT_W-1:0] buf_count;
  logic [15:0]          buf_hw0, buf_hw1;
  logic [1:0]           push_cnt, pop_cnt;
  logic [15:0]          push_hw0, push_hw1;

  logic req_acc, rsp_keep, compressed, issue;

  assign mem_req_vld  = (state_q == StReq);
  assign mem_req_addr = fetch_q;

  assign req_acc    = mem_req_vld && mem_req_rdy;
  assign rsp_keep   = (state_q == StWait) && mem_rsp_vld && !redirect_vld;
  assign compressed = is_compressed(buf_hw0);
  assign issue      = !stall && !redirect_vld &&
                      (compressed ? (buf_count != '0) : (buf_count >= IFU_CNT_W'(2)));

  // Fetch FSM. A request is only started with room for two more halfwords, so a response can
  // always be absorbed without overflowing the buffer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!redirect_vld && (buf_count <= IFU_CNT_W'(2))) state_d = StReq;
      end
      StReq: begin
        // A redirect withdraws the request; if memory took it this very cycle, its data
        // still has to be drained and discarded.
        if (redirect_vld)     state_d = mem_req_rdy ? StDrop : StIdle;
        else if (mem_req_rdy) state_d = StWait;
      end
      StWait: begin
        if (redirect_vld)     state_d = mem_rsp_vld ? StIdle : StDrop;
        else if (mem_rsp_vld) state_d = StIdle;
      end
      StDrop: begin
        if (mem_rsp_vld) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    fetch_d    = fetch_q;
    skip_lo_d  = skip_lo_q;
    ifu_vld_d  = issue;
    ifu_addr_d = ifu_addr_q;
    ifu_data_d = ifu_data_q;
    push_cnt   = 2'd0;
    push_hw0   = mem_rsp_data[15:0];
    push_hw1   = mem_rsp_data[31:16];
    pop_cnt    = 2'd0;

    if (req_acc) fetch_d = fetch_q + 32'd4;

    if (rsp_keep) begin
      skip_lo_d = 1'b0;
      if (skip_lo_q) begin
        push_cnt = 2'd1;
        push_hw0 = mem_rsp_data[31:16];
      end else begin
        push_cnt = 2'd2;
      end
    end

    if (issue) begin
      ifu_addr_d = pc_q;
      if (compressed) begin
        ifu_data_d = {16'h0000, buf_hw0};
        pop_cnt    = 2'd1;
        pc_d       = pc_q + 32'd2;
      end else begin
        ifu_data_d = {buf_hw1, buf_hw0};
        pop_cnt    = 2'd2;
        pc_d       = pc_q + 32'd4;
      end
    end

    // Redirect overrides everything above; issue and push are already gated off by it.
    if (redirect_vld) begin
      pc_d      = {redirect_addr[31:1], 1'b0};
      fetch_d   = {redirect_addr[31:2], 2'b00};
      skip_lo_d = redirect_addr[1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_ADDR;
      fetch_q    <= {RESET_ADDR[31:2], 2'b00};
      skip_lo_q  <= RESET_ADDR[1];
      ifu_vld_q  <= 1'b0;
      ifu_addr_q <= '0;
      ifu_data_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_q    <= fetch_d;
      skip_lo_q  <= skip_lo_d;
      ifu_vld_q  <= ifu_vld_d;
      ifu_addr_q <= ifu_addr_d;
      ifu_data_q <= ifu_data_d;
    end
  end

  riscv_ifu_hwbuf #(
    .Depth (IFU_BUF_DEPTH)
  ) u_hwbuf (
    .clock    (clock),
    .reset    (reset),
    .flush    (redirect_vld),
    .push_cnt (push_cnt),
    .push_hw0 (push_hw0),
    .push_hw1 (push_hw1),
    .pop_cnt  (pop_cnt),
    .count    (buf_count),
    .hw0      (buf_hw0),
    .hw1      (buf_hw1)
  );

  assign ifu_vld  = ifu_vld_q;
  assign ifu_addr = ifu_addr_q;
  assign ifu_data = ifu_data_q;

endmodule

// File: tb/tb_riscv_ifu.sv
// Self-checking bench for riscv_ifu. A small memory model answers fetch requests with
// configurable readiness and latency; expected issues are derived from the memory image by
// walking the instruction stream from the architectural PC.
module tb_riscv_ifu;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_vld = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        stall = 1'b0;
  logic        mem_req_vld;
  logic        mem_req_rdy = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_vld = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        ifu_vld;
  logic [31:0] ifu_addr;
  logic [31:0] ifu_data;

  riscv_ifu #(
    .RESET_ADDR (RESET_ADDR)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .redirect_vld  (redirect_vld),
    .redirect_addr (redirect_addr),
    .stall         (stall),
    .mem_req_vld   (mem_req_vld),
    .mem_req_rdy   (mem_req_rdy),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_vld   (mem_rsp_vld),
    .mem_rsp_data  (mem_rsp_data),
    .ifu_vld       (ifu_vld),
    .ifu_addr      (ifu_addr),
    .ifu_data      (ifu_data)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Memory model state
  logic [31:0] mem [0:255];
  int          rdy_pct = 100;
  int          lat_min = 0;
  int          lat_max = 0;
  logic        busy = 1'b0;
  int          lat_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic        acc_fired = 1'b0;
  logic        rsp_fired = 1'b0;
  logic [31:0] acc_addr = '0;
  logic [31:0] rsp_addr = '0;

  function automatic logic [15:0] mem_hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Reference: the instruction that starts at pc, from the memory image alone.
  function automatic logic [31:0] ref_data(input logic [31:0] pc);
    logic [15:0] lo;
    lo = mem_hw(pc);
    if (lo[1:0] != 2'b11) return {16'h0000, lo};
    return {mem_hw(pc + 32'd2), lo};
  endfunction

  function automatic logic [31:0] ref_len(input logic [31:0] pc);
    logic [15:0] lo;
    lo = mem_hw(pc);
    return (lo[1:0] != 2'b11) ? 32'd2 : 32'd4;
  endfunction

  task automatic fill_mem(input logic [31:0] w);
    for (int i = 0; i < 256; i++) mem[i] = w;
  endtask

  // One clock cycle: records handshakes seen at the edge, then drives the memory inputs for
  // the following cycle. Sampling happens 1 time unit after the rising edge.
  task automatic tick();
    logic        acc;
    logic        rsp;
    logic [31:0] a;
    acc = (mem_req_vld === 1'b1) && (mem_req_rdy === 1'b1);
    rsp = (mem_rsp_vld === 1'b1);
    a   = mem_req_addr;
    @(posedge clock);
    #1;
    cyc++;
    acc_fired = acc;
    acc_addr  = a;
    rsp_fired = rsp;
    rsp_addr  = pend_addr;
    if (rsp) busy = 1'b0;
    if (acc) begin
      busy      = 1'b1;
      pend_addr = a;
      lat_cnt   = $urandom_range(lat_max, lat_min);
    end
    if (busy && lat_cnt == 0) begin
      mem_rsp_vld  = 1'b1;
      mem_rsp_data = mem[pend_addr[9:2]];
    end else begin
      mem_rsp_vld  = 1'b0;
      mem_rsp_data = $urandom;
      if (busy) lat_cnt--;
    end
    mem_req_rdy = !busy && (int'($urandom_range(99, 0)) < rdy_pct);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    redirect_vld = 1'b0;
    stall        = 1'b0;
    tick();
    tick();
    busy        = 1'b0;
    mem_rsp_vld = 1'b0;
    mem_req_rdy = 1'b0;
    reset       = 1'b0;
  endtask

  task automatic wait_issue(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ifu_vld === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_acc(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (acc_fired) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    fill_mem(32'h0000_0013);
    rdy_pct = 100;
    lat_min = 0;
    lat_max = 0;
    reset   = 1'b1;
    tick();
    tick();
    checks++;
    if (mem_req_vld !== 1'b0) begin
      failures++;
      $display("FAIL reset_req_vld: got %b expected 0", mem_req_vld);
    end
    checks++;
    if (ifu_vld !== 1'b0) begin
      failures++;
      $display("FAIL reset_ifu_vld: got %b expected 0", ifu_vld);
    end
    checks++;
    if (ifu_addr !== 32'h0 || ifu_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_ifu_out: got addr %h data %h expected 0/0", ifu_addr, ifu_data);
    end
    reset = 1'b0;
    busy  = 1'b0;
    tick();
    checks++;
    if (mem_req_vld !== 1'b1 || mem_req_addr !== RESET_ADDR) begin
      failures++;
      $display("FAIL reset_first_req: got vld %b addr %h expected 1/%h",
               mem_req_vld, mem_req_addr, RESET_ADDR);
    end
  endtask

  task automatic test_two_words();
    bit found;
    fill_mem(32'h0000_0013);
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    rdy_pct = 100;
    lat_min = 0;
    lat_max = 0;
    do_reset();
    wait_issue(40, found);
    checks++;
    if (!found || ifu_addr !== 32'h0 || ifu_data !== 32'h0050_0093) begin
      failures++;
      $display("FAIL two_words_0: got found %b addr %h data %h expected 1/00000000/00500093",
               found, ifu_addr, ifu_data);
    end
    wait_issue(40, found);
    checks++;
    if (!found || ifu_addr !== 32'h4 || ifu_data !== 32'h00A0_0113) begin
      failures++;
      $display("FAIL two_words_1: got found %b addr %h data %h expected 1/00000004/00a00113",
               found, ifu_addr, ifu_data);
    end
  endtask

  task automatic test_compressed();
    bit found;
    fill_mem(32'h0000_0013);
    mem[0] = 32'h0093_4505;
    mem[1] = 32'h0000_0000;
    rdy_pct = 70;
    lat_min = 0;
    lat_max = 2;
    do_reset();
    wait_issue(40, found);
    checks++;
    if (!found || ifu_addr !== 32'h0 || ifu_data !== 32'h0000_4505) begin
      failures++;
      $display("FAIL compressed_0: got found %b addr %h data %h expected 1/00000000/00004505",
               found, ifu_addr, ifu_data);
    end
    wait_issue(40, found);
    checks++;
    if (!found || ifu_addr !== 32'h2 || ifu_data !== 32'h0000_0093) begin
      failures++;
      $display("FAIL compressed_1: got found %b addr %h data %h expected 1/00000002/00000093",
               found, ifu_addr, ifu_data);
    end
  endtask

  task automatic test_split();
    bit found;
    bit got;
    int resp_cyc;
    fill_mem(32'h0000_0013);
    mem[0] = 32'h0093_4505;
    mem[1] = {16'($urandom), 16'h0050};
    rdy_pct = 60;
    lat_min = 0;
    lat_max = 3;
    do_reset();
    wait_issue(40, found);
    checks++;
    if (!found || ifu_addr !== 32'h0 || ifu_data !== 32'h0000_4505) begin
      failures++;
      $display("FAIL split_first: got found %b addr %h data %h expected 1/00000000/00004505",
               found, ifu_addr, ifu_data);
    end
    got      = 1'b0;
    resp_cyc = -10;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ifu_vld === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (rsp_fired && rsp_addr == 32'h4) resp_cyc = cyc;
    end
    checks++;
    if (!got || cyc != resp_cyc + 1 || ifu_addr !== 32'h2 || ifu_data !== 32'h0050_0093) begin
      failures++;
      $display("FAIL split_issue: got found %b lat %0d addr %h data %h expected 1/1/00000002/00500093",
               got, cyc - resp_cyc, ifu_addr, ifu_data);
    end
  endtask

  task automatic test_redirect();
    bit found;
    fill_mem(32'h0000_0013);
    mem[0]  = 32'h0050_0093;
    mem[64] = 32'h4505_FFFF;
    rdy_pct = 100;
    lat_min = 6;
    lat_max = 6;
    do_reset();
    wait_acc(20, found);
    tick();
    redirect_vld  = 1'b1;
    redirect_addr = 32'h0000_0102;
    tick();
    redirect_vld = 1'b0;
    lat_min      = 1;
    lat_max      = 1;
    checks++;
    if (!found || ifu_vld !== 1'b0) begin
      failures++;
      $display("FAIL redirect_vld_low: got found %b ifu_vld %b expected 1/0", found, ifu_vld);
    end
    wait_acc(30, found);
    checks++;
    if (!found || acc_addr !== 32'h0000_0100) begin
      failures++;
      $display("FAIL redirect_req_addr: got found %b addr %h expected 1/00000100", found, acc_addr);
    end
    wait_issue(40, found);
    checks++;
    if (!found || ifu_addr !== 32'h0000_0102 || ifu_data !== 32'h0000_4505) begin
      failures++;
      $display("FAIL redirect_issue: got found %b addr %h data %h expected 1/00000102/00004505",
               found, ifu_addr, ifu_data);
    end
  endtask

  task automatic test_stall();
    int vld_seen;
    fill_mem(32'h0000_0013);
    mem[0] = 32'h0001_4505;
    mem[1] = 32'h00A0_0113;
    rdy_pct = 100;
    lat_min = 0;
    lat_max = 0;
    do_reset();
    stall    = 1'b1;
    vld_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ifu_vld !== 1'b0) vld_seen++;
    end
    checks++;
    if (vld_seen != 0) begin
      failures++;
      $display("FAIL stall_fill_vld: got %0d issues expected 0", vld_seen);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (mem_req_vld !== 1'b0 || ifu_vld !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold_%0d: got req %b ifu_vld %b expected 0/0", i, mem_req_vld, ifu_vld);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (ifu_vld !== 1'b1 || ifu_addr !== 32'h0 || ifu_data !== 32'h0000_4505) begin
      failures++;
      $display("FAIL stall_resume_0: got vld %b addr %h data %h expected 1/00000000/00004505",
               ifu_vld, ifu_addr, ifu_data);
    end
    tick();
    checks++;
    if (ifu_vld !== 1'b1 || ifu_addr !== 32'h2 || ifu_data !== 32'h0000_0001) begin
      failures++;
      $display("FAIL stall_resume_1: got vld %b addr %h data %h expected 1/00000002/00000001",
               ifu_vld, ifu_addr, ifu_data);
    end
    tick();
    checks++;
    if (ifu_vld !== 1'b1 || ifu_addr !== 32'h4 || ifu_data !== 32'h00A0_0113) begin
      failures++;
      $display("FAIL stall_resume_2: got vld %b addr %h data %h expected 1/00000004/00a00113",
               ifu_vld, ifu_addr, ifu_data);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    fill_mem(32'h0000_0013);
    mem[0] = 32'h0050_0093;
    rdy_pct = 100;
    lat_min = 8;
    lat_max = 8;
    do_reset();
    wait_acc(20, found);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    // Stale response for the abandoned request, arriving while the unit sits in IDLE.
    mem_rsp_vld  = 1'b1;
    mem_rsp_data = 32'h0000_4505;
    lat_min      = 0;
    lat_max      = 1;
    checks++;
    if (!found || ifu_vld !== 1'b0 || mem_req_vld !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_state: got found %b ifu_vld %b req %b expected 1/0/0",
               found, ifu_vld, mem_req_vld);
    end
    wait_acc(30, found);
    checks++;
    if (!found || acc_addr !== RESET_ADDR) begin
      failures++;
      $display("FAIL reset_mid_req: got found %b addr %h expected 1/%h", found, acc_addr, RESET_ADDR);
    end
    wait_issue(40, found);
    checks++;
    if (!found || ifu_addr !== RESET_ADDR || ifu_data !== 32'h0050_0093) begin
      failures++;
      $display("FAIL reset_mid_issue: got found %b addr %h data %h expected 1/%h/00500093",
               found, ifu_addr, ifu_data, RESET_ADDR);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] exp_data;
    logic [15:0] h0, h1;
    logic        pv, pr, redir;
    logic [31:0] pa;
    int          issued;
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < 256; i++) begin
        h0 = 16'($urandom);
        h1 = 16'($urandom);
        if ($urandom_range(1, 0) == 1) h0[1:0] = 2'b11;
        if ($urandom_range(1, 0) == 1) h1[1:0] = 2'b11;
        mem[i] = {h1, h0};
      end
      rdy_pct = int'($urandom_range(100, 30));
      lat_min = 0;
      lat_max = int'($urandom_range(3, 0));
      do_reset();
      exp_pc = RESET_ADDR;
      issued = 0;
      for (int c = 0; c < 600; c++) begin
        stall = ($urandom_range(99, 0) < 20);
        redir = ($urandom_range(99, 0) < 3);
        redirect_vld = redir;
        if (redir) begin
          redirect_addr = $urandom;
          if ($urandom_range(3, 0) == 0) redirect_addr = 32'hFFFF_FFF8 | ($urandom & 32'h7);
        end
        pv = mem_req_vld;
        pr = mem_req_rdy;
        pa = mem_req_addr;
        tick();
        if (redir) begin
          checks++;
          if (ifu_vld !== 1'b0) begin
            failures++;
            $display("FAIL rand_redirect_vld: got %b expected 0 (cycle %0d)", ifu_vld, cyc);
          end
          exp_pc = {redirect_addr[31:1], 1'b0};
        end else if (ifu_vld === 1'b1) begin
          exp_data = ref_data(exp_pc);
          checks++;
          if (ifu_addr !== exp_pc || ifu_data !== exp_data) begin
            failures++;
            $display("FAIL rand_issue: got addr %h data %h expected %h/%h (cycle %0d)",
                     ifu_addr, ifu_data, exp_pc, exp_data, cyc);
          end
          exp_pc = exp_pc + ref_len(exp_pc);
          issued++;
        end
        if (pv === 1'b1 && pr !== 1'b1 && !redir) begin
          checks++;
          if (mem_req_vld !== 1'b1 || mem_req_addr !== pa) begin
            failures++;
            $display("FAIL rand_req_hold: got vld %b addr %h expected 1/%h (cycle %0d)",
                     mem_req_vld, mem_req_addr, pa, cyc);
          end
        end
      end
      redirect_vld = 1'b0;
      stall        = 1'b0;
      checks++;
      if (issued < 40) begin
        failures++;
        $display("FAIL rand_progress: got %0d issues expected at least 40", issued);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_compressed();
    test_split();
    test_redirect();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
